// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit, one bit per cycle, 34-cycle latency at XLEN=32.
// Optional macro MULDIV_FASTPATH_EN: zero/overflow/divide-by-zero requests complete in one cycle.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            Start,
    input  logic            Kill,
    input  logic [2:0]      MulDivOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic              div_zero_q, div_zero_d, ovf_q, ovf_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              accept, a_signed, b_signed, sign_a_in, sign_b_in;
    logic              div_zero_in, ovf_in, fast_hit;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Request decode: operand magnitudes and special-case detection
    always_comb begin
        accept      = (state_q == IDLE) && Start && !Kill;
        a_signed    = MulDivOp inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed    = MulDivOp inside {3'b001, 3'b100, 3'b110};
        sign_a_in   = a_signed && SrcA[XLEN-1];
        sign_b_in   = b_signed && SrcB[XLEN-1];
        a_mag       = sign_a_in ? -SrcA : SrcA;
        b_mag       = sign_b_in ? -SrcB : SrcB;
        div_zero_in = MulDivOp[2] && (SrcB == '0);
        ovf_in      = MulDivOp[2] && !MulDivOp[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    end

`ifdef MULDIV_FASTPATH_EN
    logic [XLEN-1:0] fast_res;
    always_comb begin
        fast_hit = div_zero_in || ovf_in || (SrcA == '0) || (!MulDivOp[2] && (SrcB == '0));
        fast_res = '0;
        if (div_zero_in) begin
            fast_res = MulDivOp[1] ? SrcA : '1;
        end else if (ovf_in) begin
            fast_res = MulDivOp[1] ? '0 : MIN_NEG;
        end
    end
`else
    assign fast_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            result_q   <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            result_q   <= result_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next state; Kill overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = fast_hit ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (Kill) state_d = IDLE;
    end

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_res;

    // Sign correction and final result selection, special cases forced
    always_comb begin
        prod_s  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_s  = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s   = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res = '0;
        unique case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = div_zero_q ? '1 : (ovf_q ? MIN_NEG : quot_s);
            default:                fix_res = div_zero_q ? a_raw_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        result_d   = result_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift  = acc_q[2*XLEN-1:XLEN-1];
        div_diff   = div_shift - {1'b0, opnd_q};
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // multiply: acc low = multiplier; divide: acc low = dividend
                    op_d       = MulDivOp;
                    cnt_d      = '0;
                    acc_d      = {{XLEN{1'b0}}, (MulDivOp[2] ? a_mag : b_mag)};
                    opnd_d     = MulDivOp[2] ? b_mag : a_mag;
                    a_raw_d    = SrcA;
                    sign_a_d   = sign_a_in;
                    sign_b_d   = sign_b_in;
                    div_zero_d = div_zero_in;
                    ovf_d      = ovf_in;
`ifdef MULDIV_FASTPATH_EN
                    if (fast_hit) result_d = fast_res;
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                           : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
            end
            FIX:     result_d = fix_res;
            default: ;
        endcase
        if (Kill) result_d = result_q;
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus Kill/reset/back-to-back sequences, scoreboard on Done.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam int SLOW_LAT = 34;
`ifdef MULDIV_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 34;
`endif

    logic        clk, reset_n, Start, Kill, Busy, Done;
    logic [2:0]  MulDivOp;
    logic [31:0] SrcA, SrcB, Result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .Kill(Kill), .MulDivOp(MulDivOp),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          fast;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        int          id;
    } sb_t;

    sb_t         sb_q[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          next_id = 0;
    logic [31:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        sa, sb, ua, ub, p;
        logic signed [31:0] sa32, sb32;
        logic               ovf;
        logic [31:0]        r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        sa32 = a;
        sb32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p    = '0;
        r    = '0;
        case (op)
            MUL:    begin p = ua * ub; r = p[31:0];  end
            MULH:   begin p = sa * sb; r = p[63:32]; end
            MULHSU: begin p = sa * ub; r = p[63:32]; end
            MULHU:  begin p = ua * ub; r = p[63:32]; end
            DIV:    r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa32 / sb32));
            DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    r = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa32 % sb32));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Scoreboard: every Done pops one pending request and checks value and latency
    always @(posedge clk) begin
        #1;
        if (Done) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_done: Done=1 at cycle %0d with no pending request", cyc);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk($sformatf("req%0d_result", e.id), Result, e.res);
                chk($sformatf("req%0d_latency", e.id), 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic push_exp(input logic [31:0] res, input int lat);
        sb_q.push_back('{res: res, lat: lat, t0: cyc, id: next_id});
        next_id++;
        last_exp = res;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] res, input int lat);
        @(negedge clk);
        Start = 1'b1; MulDivOp = op; SrcA = a; SrcB = b;
        if (push) push_exp(res, lat);
        @(negedge clk);
        Start = 1'b0; MulDivOp = 3'($urandom_range(0, 7)); SrcA = $urandom(); SrcB = $urandom();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !Busy) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL wait_idle_timeout: pending=%0d busy=%0b", sb_q.size(), Busy);
            sb_q.delete();
        end
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{MUL,    32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0},
            '{MULH,   32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0},
            '{MULHU,  32'd7,          32'hFFFF_FFFA, 32'h0000_0006, 1'b0},
            '{MULHSU, 32'd7,          32'hFFFF_FFFA, 32'h0000_0006, 1'b0},
            '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0},
            '{MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
            '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
            '{MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
            '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0},
            '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
            '{MUL,    32'h0001_0001,  32'h0001_0001, 32'h0002_0001, 1'b0},
            '{MULHU,  32'h0001_0001,  32'h0001_0001, 32'h0000_0001, 1'b0},
            '{DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0},
            '{REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 1'b0},
            '{DIVU,   32'd20,         32'd3,         32'd6,         1'b0},
            '{REMU,   32'd20,         32'd3,         32'd2,         1'b0},
            '{DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0},
            '{REM,    32'd100,        32'hFFFF_FFF9, 32'd2,         1'b0},
            '{DIV,    32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        1'b0},
            '{REM,    32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0},
            '{DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0},
            '{REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 1'b0},
            '{DIVU,   32'd5,          32'd7,         32'd0,         1'b0},
            '{REMU,   32'd5,          32'd7,         32'd5,         1'b0},
            '{DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0},
            '{DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0},
            '{REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
            '{DIVU,   32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1},
            '{REM,    32'h1234_5678,  32'd0,         32'h1234_5678, 1'b1},
            '{DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1},
            '{REMU,   32'h8000_0001,  32'd0,         32'h8000_0001, 1'b1},
            '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
            '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1},
            '{DIV,    32'd0,          32'd5,         32'd0,         1'b1},
            '{MUL,    32'd5,          32'd0,         32'd0,         1'b1},
            '{MULH,   32'd0,          32'hFFFF_FFFF, 32'd0,         1'b1}
        };

        reset_n = 1'b0; Start = 1'b0; Kill = 1'b0; MulDivOp = '0; SrcA = '0; SrcB = '0;
        #3;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_result", Result, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res,
                  vecs[i].fast ? FAST_LAT : SLOW_LAT);
            wait_idle();
        end

        // Random non-trivial operands against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom() | 32'h1;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : ($urandom() | 32'h1);
            issue(op, a, b, 1'b1, model(op, a, b), SLOW_LAT);
            wait_idle();
        end

        // Kill and Start together in IDLE: nothing starts
        @(negedge clk);
        Start = 1'b1; Kill = 1'b1; MulDivOp = DIVU; SrcA = 32'd77; SrcB = 32'd3;
        @(negedge clk);
        Start = 1'b0; Kill = 1'b0;
        chk("kill_start_busy", 32'(Busy), 32'd0);
        repeat (3) @(negedge clk);

        // Kill at cycle 10, restart at cycle 11, Done expected at cycle 45
        issue(DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 0);
        repeat (9) @(negedge clk);
        Kill = 1'b1;
        @(negedge clk);
        Kill = 1'b0;
        chk("kill_busy", 32'(Busy), 32'd0);
        chk("kill_result_held", Result, last_exp);
        Start = 1'b1; MulDivOp = DIVU; SrcA = 32'd20; SrcB = 32'd3;
        push_exp(32'd6, 45 - 11);
        @(negedge clk);
        Start = 1'b0; SrcA = $urandom(); SrcB = $urandom();
        wait_idle();

        // Async reset mid-CALC clears outputs without a clock edge
        issue(MUL, 32'd3, 32'd5, 1'b0, 32'd0, 0);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_busy", 32'(Busy), 32'd0);
        chk("async_reset_done", 32'(Done), 32'd0);
        chk("async_reset_result", Result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_exp = '0;
        repeat (2) @(negedge clk);

        // Start held high with changing operands: accepted only at cycles 0 and 35
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            Start    = 1'b1;
            MulDivOp = (c % 2 == 1) ? DIVU : MULHU;
            SrcA     = $urandom() | 32'h1;
            SrcB     = 32'($urandom_range(1, 50000));
            if (c == 0 || c == 35) push_exp(model(MulDivOp, SrcA, SrcB), SLOW_LAT);
        end
        @(negedge clk);
        Start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Consumes the same SrcA/SrcB operands from the operand-select muxes.
- Drives a result into the writeback result mux downstream of ALUResult.
- Radix-2, one bit per cycle. The hazard unit stalls the pipeline while Busy is high.

Parameters:
- XLEN, 32, operand/result width; the iteration counter is clog2(XLEN) bits wide.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Kill  input  1  pipeline flush; aborts any operation in flight.
- MulDivOp  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  XLEN  rs1 operand (multiplicand/dividend).
- SrcB  input  XLEN  rs2 operand (multiplier/divisor).
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; Result valid in that cycle.
- Result  output  XLEN  registered result; holds its value until the next Done.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, Busy=0, Done=0, Result=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Start=1 and Kill=0: latch MulDivOp.
  - Latch operand magnitudes. A signed operand is negated when its MSB=1: both for MULH/DIV/REM; SrcA only for MULHSU.
  - Latch result sign flags; counter=0; go to CALC.
- CALC: one shift-add (MUL*) or shift-subtract-restore (DIV*/REM*) step per cycle.
  - Counter increments each cycle; on counter==XLEN-1 go to FIX. CALC lasts exactly XLEN cycles.
- FIX:
  - Apply sign correction: product negated if signA^signB; quotient negated if signA^signB; remainder takes the sign of the dividend.
  - Select the output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV* = quotient; REM* = remainder.
  - Load Result; go to DONE.
- DONE: Done=1 for this single cycle; next state IDLE.
  - Start is not accepted in DONE; a back-to-back Start is accepted in the following IDLE cycle.
- Latency: Start high in cycle 0 gives CALC in cycles 1..32, FIX in cycle 33, Done=1 in cycle 34 (XLEN=32).
- Start while Busy=1: ignored, no effect on the operation in flight.
- Kill: highest priority in any state.
  - Next state IDLE, Done stays 0, Result unchanged.
  - Kill and Start in the same IDLE cycle: Start ignored.
- Divide by zero (SrcB=0), no trap:
  - DIV/DIVU quotient = all ones.
  - REM/REMU remainder = SrcA.
- Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF):
  - DIV = 0x80000000.
  - REM = 0.
- Both special cases are forced in FIX, independent of the iteration datapath.
- Operand inputs may change after the Start cycle; only latched copies are used.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined:
  - In IDLE, with Start=1, detect: divide-by-zero, signed overflow, SrcA==0 for any op, or SrcB==0 for MUL*.
  - On detection, skip CALC/FIX: load the architected result directly and go straight to DONE.
  - Done in cycle 1. All other operations keep the 34-cycle latency.
- Undefined: every operation takes exactly 34 cycles. Special-case results are unchanged.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFA (-6) -> Done at cycle 34, Result=0xFFFFFFD6; MULH same operands -> 0xFFFFFFFF; MULHU same operands -> 0x00000006.
- DIV SrcA=0xFFFFFFEC (-20), SrcB=3 -> Result=0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2); DIVU 20/3 -> 6; REMU 20/3 -> 2.
- DIVU SrcB=0 -> 0xFFFFFFFF; REM SrcA=0x12345678, SrcB=0 -> 0x12345678. Fast path defined -> Done at cycle 1, else cycle 34.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start DIVU; pulse Kill at cycle 10 -> Busy=0 at cycle 11, no Done pulse, Result unchanged. Second Start accepted at cycle 11 -> Done at cycle 45.
- Start asserted continuously with new operands during Busy -> exactly one Done per accepted request. Assert reset_n=0 mid-CALC -> Busy/Done/Result=0 immediately, without waiting for a clock edge.
